hit_capture: RTL and testbench
==============================

# hit_capture

Front-end input stage for play mode. It debounces the raw note, length and octave keys and tracks the current octave. Each note-key press becomes a single timestamped hit event (clock, octave, note, length). The event is held in a one-entry valid/ready buffer that the play-mode scoring/sound stage drains.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 200000, clk cycles between debounce sampling ticks (2 ms at 100 MHz); minimum 2
- OCT_MAX, 2, highest octave code
- OCT_DEFAULT, 1, octave after reset / while disabled
- DEFAULT_LENGTH, 2, length code used when no length key is held

Ports:
- clk  in  1  system clock, single clock domain
- rst_n  in  1  reset; asynchronous, active-low
- en  in  1  play mode active
- note_key  in  `NOTE_KEY_BITS (7)  raw note switches, bit i = note i+1
- length_key  in  `LENGTH_KEY_BITS (4)  raw length switches, bit j = length code j
- oct_up, oct_down  in  1  raw octave buttons
- system_clock  in  `CLOCK_BITS  free-running song timebase
- hit_ready  in  1  consumer accepts the buffered event
- hit_valid  out  1  event buffered
- hit_clock  out  `CLOCK_BITS  system_clock at detection
- hit_octave  out  `OCTAVE_BITS (2)  octave of the event
- hit_note  out  `NOTE_BITS (3)  1..7; 0 never issued
- hit_length  out  `LENGTH_BITS (2)  length code
- octave  out  2  current octave, for display
- hit_drop  out  1  one-cycle pulse: an event was lost

## Operation
- Tick counter counts 0..DEBOUNCE_CYCLES-1 and wraps. tick = (count == DEBOUNCE_CYCLES-1).
- The 13 raw inputs are grouped as {oct_up, oct_down, length_key, note_key}.
- On each tick:
  - sample register ← raw inputs.
  - For each bit where raw == sample (equal on two consecutive ticks), stable ← raw.
- Rising edges are computed only on tick cycles: rise = next_stable & ~stable.
- Octave:
  - rise(oct_up) alone: octave+1, saturating at OCT_MAX.
  - rise(oct_down) alone: octave-1, saturating at 0.
  - Both rise on the same tick: no change.
- Note event:
  - Any rise in the note bits creates one event. The lowest-index rising bit wins; simultaneous other rises are discarded without a drop pulse.
  - Keys that are held but not rising never create events.
  - Event fields:
    - hit_note = winning index+1.
    - hit_octave = octave value before any same-tick octave update.
    - hit_length = lowest set bit of next_stable length bits, or DEFAULT_LENGTH if none are set.
    - hit_clock = system_clock in the detection cycle.
- Buffer:
  - Event with buffer empty, or with hit_valid & hit_ready: load fields, hit_valid=1.
  - hit_valid & hit_ready with no event: hit_valid=0; fields hold their last values.
  - Event while hit_valid & ~hit_ready: event dropped, buffer unchanged, hit_drop=1 next cycle.
- en=0, applied synchronously:
  - tick counter cleared.
  - sample and stable are loaded from raw every cycle, so keys already held at enable do not fire.
  - octave = OCT_DEFAULT; hit_valid=0; hit_drop=0.

## Timing
- Reset (rst_n low, asynchronous) sets:
  - octave = OCT_DEFAULT.
  - hit_valid, hit_drop, hit_clock, hit_octave, hit_note, hit_length = 0.
  - counter, sample and stable = 0.
- Raw press to hit_valid: the press must be seen on two consecutive ticks. hit_valid rises at the clock edge of the second tick, so the latency is DEBOUNCE_CYCLES+1 to 2·DEBOUNCE_CYCLES cycles.
- The octave update is visible on the same edge as the corresponding stable update.
- A glitch shorter than DEBOUNCE_CYCLES produces no event.
- A release followed by a re-press each need two matching ticks, so one event is issued per physical press.
- Handshake:
  - Transfer occurs on an edge with hit_valid & hit_ready.
  - hit_ready is ignored while hit_valid=0.
  - Fields are stable while hit_valid=1.
- rst_n asserted mid-press clears everything immediately. After release, a still-held key fires only after two matching ticks with stable starting from 0.
- system_clock wrap-around is passed through unchanged. No saturation, no arithmetic on it.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, OCT_MAX=2, OCT_DEFAULT=1, DEFAULT_LENGTH=2.
- Press note_key bit2 with length_key=4'b0001, en=1, octave=1, hit_ready=0 → within 8 cycles: hit_valid=1, hit_note=3, hit_octave=1, hit_length=0, hit_clock = system_clock at that edge. Hold for 40 cycles → no further event.
- 3-cycle pulse on note_key bit0 → hit_valid stays 0.
- Three oct_up presses → octave 2 then 2. Four oct_down presses → 1, 0, 0, 0. Both buttons pressed together → no change.
- note_key bits 4 and 1 rise on the same tick → one event with hit_note=2, no hit_drop.
- Event buffered and hit_ready=0, then a second press → hit_drop pulses once and the first event's fields are unchanged. Raise hit_ready while a third press is detected on the same edge → hit_valid stays 1 with the third event loaded.
- Note held while en rises → no event. Assert rst_n=0 mid-press → all outputs clear asynchronously, octave=1.

Source files
------------

// File: rtl/hit_capture.sv
// Play-mode input front end: debounces note/length/octave keys, tracks the octave,
// and turns each note-key press into one timestamped event held in a valid/ready buffer.
`ifndef NOTE_KEY_BITS
`define NOTE_KEY_BITS 7
`endif
`ifndef LENGTH_KEY_BITS
`define LENGTH_KEY_BITS 4
`endif
`ifndef CLOCK_BITS
`define CLOCK_BITS 16
`endif
`ifndef OCTAVE_BITS
`define OCTAVE_BITS 2
`endif
`ifndef NOTE_BITS
`define NOTE_BITS 3
`endif
`ifndef LENGTH_BITS
`define LENGTH_BITS 2
`endif

module hit_capture #(
   parameter int DEBOUNCE_CYCLES = 200000,
   parameter int OCT_MAX         = 2,
   parameter int OCT_DEFAULT     = 1,
   parameter int DEFAULT_LENGTH  = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        en,
   input  logic [`NOTE_KEY_BITS-1:0]   note_key,
   input  logic [`LENGTH_KEY_BITS-1:0] length_key,
   input  logic                        oct_up,
   input  logic                        oct_down,
   input  logic [`CLOCK_BITS-1:0]      system_clock,
   input  logic                        hit_ready,
   output logic                        hit_valid,
   output logic [`CLOCK_BITS-1:0]      hit_clock,
   output logic [`OCTAVE_BITS-1:0]     hit_octave,
   output logic [`NOTE_BITS-1:0]       hit_note,
   output logic [`LENGTH_BITS-1:0]     hit_length,
   output logic [`OCTAVE_BITS-1:0]     octave,
   output logic                        hit_drop
);

   localparam int NK    = `NOTE_KEY_BITS;
   localparam int LK    = `LENGTH_KEY_BITS;
   localparam int RAW_W = NK + LK + 2;
   localparam int CW    = $clog2(DEBOUNCE_CYCLES);

   logic [CW-1:0]           count;
   logic                    tick;
   logic [RAW_W-1:0]        raw;
   logic [RAW_W-1:0]        sample;
   logic [RAW_W-1:0]        stable;
   logic [RAW_W-1:0]        next_stable;
   logic [RAW_W-1:0]        rise;
   logic                    ev;
   logic [`NOTE_BITS-1:0]   ev_note;
   logic [`LENGTH_BITS-1:0] ev_len;
   logic [`OCTAVE_BITS-1:0] oct_next;
   logic                    load;
   logic                    drop_next;

   assign raw  = {oct_up, oct_down, length_key, note_key};
   assign tick = (count == CW'(DEBOUNCE_CYCLES - 1));

   // A bit only moves to its raw value once two consecutive ticks agree.
   assign next_stable = (raw & ~(raw ^ sample)) | (stable & (raw ^ sample));
   assign rise        = tick ? (next_stable & ~stable) : '0;

   always_comb begin
      ev      = 1'b0;
      ev_note = '0;
      for (int i = NK - 1; i >= 0; i--) begin
         if (rise[i]) begin
            ev      = 1'b1;
            ev_note = `NOTE_BITS'(i + 1);
         end
      end
      ev_len = `LENGTH_BITS'(DEFAULT_LENGTH);
      for (int j = LK - 1; j >= 0; j--) begin
         if (next_stable[NK + j]) ev_len = `LENGTH_BITS'(j);
      end
   end

   always_comb begin
      oct_next = octave;
      if (rise[RAW_W-1] && !rise[RAW_W-2] && octave != `OCTAVE_BITS'(OCT_MAX))
         oct_next = octave + `OCTAVE_BITS'(1);
      else if (rise[RAW_W-2] && !rise[RAW_W-1] && octave != '0)
         oct_next = octave - `OCTAVE_BITS'(1);
   end

   // Valid/ready: a transfer happens on any edge where hit_valid & hit_ready; the
   // buffer may reload on that same edge, and fields never change while hit_valid
   // is held without hit_ready.
   assign load      = ev && (!hit_valid || hit_ready);
   assign drop_next = ev && hit_valid && !hit_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count      <= '0;
         sample     <= '0;
         stable     <= '0;
         octave     <= `OCTAVE_BITS'(OCT_DEFAULT);
         hit_valid  <= 1'b0;
         hit_drop   <= 1'b0;
         hit_clock  <= '0;
         hit_octave <= '0;
         hit_note   <= '0;
         hit_length <= '0;
      end else if (!en) begin
         count     <= '0;
         sample    <= raw;
         stable    <= raw;
         octave    <= `OCTAVE_BITS'(OCT_DEFAULT);
         hit_valid <= 1'b0;
         hit_drop  <= 1'b0;
      end else begin
         count    <= tick ? '0 : count + CW'(1);
         hit_drop <= drop_next;
         if (tick) begin
            sample <= raw;
            stable <= next_stable;
            octave <= oct_next;
         end
         if (load) begin
            hit_valid  <= 1'b1;
            hit_clock  <= system_clock;
            hit_octave <= octave;
            hit_note   <= ev_note;
            hit_length <= ev_len;
         end else if (hit_valid && hit_ready) begin
            hit_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_hit_capture.sv
// Bench for hit_capture: directed play-mode scenarios plus random key activity,
// all checked every cycle against a behavioural model of the key/event rules.
`ifndef CLOCK_BITS
`define CLOCK_BITS 16
`endif

module tb_hit_capture;

   localparam int DEB = 4;
   localparam int CB  = `CLOCK_BITS;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic [6:0]    note_key = '0;
   logic [3:0]    length_key = '0;
   logic          oct_up = 1'b0;
   logic          oct_down = 1'b0;
   logic [CB-1:0] system_clock = CB'(16'hFFE0);
   logic          hit_ready = 1'b0;
   logic          hit_valid;
   logic [CB-1:0] hit_clock;
   logic [1:0]    hit_octave;
   logic [2:0]    hit_note;
   logic [1:0]    hit_length;
   logic [1:0]    octave;
   logic          hit_drop;

   int n_cmp = 0;
   int n_fail = 0;
   int drops_seen = 0;

   hit_capture #(
      .DEBOUNCE_CYCLES(DEB), .OCT_MAX(2), .OCT_DEFAULT(1), .DEFAULT_LENGTH(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .note_key(note_key), .length_key(length_key),
      .oct_up(oct_up), .oct_down(oct_down), .system_clock(system_clock),
      .hit_ready(hit_ready), .hit_valid(hit_valid), .hit_clock(hit_clock),
      .hit_octave(hit_octave), .hit_note(hit_note), .hit_length(hit_length),
      .octave(octave), .hit_drop(hit_drop)
   );

   // clock / timebase
   always #5 clk = ~clk;
   always @(posedge clk) begin
      #1;
      system_clock = system_clock + CB'(1);
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // behavioural model
   wire [12:0] raw = {oct_up, oct_down, length_key, note_key};
   int        m_cnt;
   bit [12:0] m_samp, m_stab;
   int        m_oct;
   bit        m_valid, m_drop;
   int        m_clk, m_foct, m_note, m_len;

   always @(posedge clk or negedge rst_n) begin : model
      bit        tk, ev;
      bit [12:0] ns, rs;
      int        nt, ln, oct_before;
      if (!rst_n) begin
         m_cnt = 0; m_samp = '0; m_stab = '0; m_oct = 1;
         m_valid = 0; m_drop = 0; m_clk = 0; m_foct = 0; m_note = 0; m_len = 0;
      end else if (!en) begin
         m_cnt = 0; m_samp = raw; m_stab = raw; m_oct = 1; m_valid = 0; m_drop = 0;
      end else begin
         tk = (m_cnt == DEB - 1);
         m_cnt = (m_cnt + 1) % DEB;
         ev = 0; nt = 0; ln = 2; oct_before = m_oct;
         if (tk) begin
            for (int i = 0; i < 13; i++) begin
               ns[i] = (raw[i] == m_samp[i]) ? raw[i] : m_stab[i];
               rs[i] = ns[i] && !m_stab[i];
            end
            for (int i = 6; i >= 0; i--) if (rs[i]) begin ev = 1; nt = i + 1; end
            for (int j = 3; j >= 0; j--) if (ns[7 + j]) ln = j;
            if (rs[12] && !rs[11]) m_oct = (m_oct < 2) ? m_oct + 1 : 2;
            else if (rs[11] && !rs[12]) m_oct = (m_oct > 0) ? m_oct - 1 : 0;
            m_samp = raw;
            m_stab = ns;
         end
         m_drop = ev && m_valid && !hit_ready;
         if (ev && (!m_valid || hit_ready)) begin
            m_valid = 1; m_clk = int'(system_clock); m_foct = oct_before; m_note = nt; m_len = ln;
         end else if (m_valid && hit_ready) begin
            m_valid = 0;
         end
      end
   end

   // compare process
   always @(negedge clk) begin
      chk("hit_valid", hit_valid, m_valid);
      chk("hit_drop", hit_drop, m_drop);
      chk("octave", octave, m_oct);
      chk("hit_clock", hit_clock, m_clk);
      chk("hit_octave", hit_octave, m_foct);
      chk("hit_note", hit_note, m_note);
      chk("hit_length", hit_length, m_len);
      if (hit_drop) drops_seen++;
   end

   // driver tasks
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_valid(input string nm, input int max_c);
      bit ok = 0;
      for (int k = 0; k < max_c; k++) begin
         @(negedge clk);
         if (hit_valid) begin ok = 1; break; end
      end
      chk(nm, ok, 1);
   endtask

   task automatic drain();
      hit_ready = 1'b1;
      cyc(1);
      hit_ready = 1'b0;
   endtask

   task automatic press_oct(input bit up, input bit down, input int exp_oct, input string nm);
      oct_up = up; oct_down = down;
      cyc(12);
      oct_up = 0; oct_down = 0;
      cyc(12);
      chk(nm, octave, exp_oct);
   endtask

   initial begin
      logic [CB-1:0] exp_c;
      int            d0;
      bit            found;

      // reset state
      cyc(2);
      chk("rst_valid", hit_valid, 0);
      chk("rst_octave", octave, 1);
      chk("rst_note", hit_note, 0);
      chk("rst_clock", hit_clock, 0);
      rst_n = 1'b1; en = 1'b1; length_key = 4'b0001;
      cyc(3);

      // single press, then long hold
      note_key = 7'b0000100;
      wait_valid("press_latency", 8);
      exp_c = system_clock - CB'(1);
      chk("press_note", hit_note, 3);
      chk("press_octave", hit_octave, 1);
      chk("press_length", hit_length, 0);
      chk("press_clock", hit_clock, exp_c);
      d0 = drops_seen;
      cyc(40);
      chk("hold_valid", hit_valid, 1);
      chk("hold_drops", drops_seen - d0, 0);
      note_key = '0; cyc(12);
      drain();
      chk("drain_valid", hit_valid, 0);

      // short glitch
      note_key = 7'b0000001; cyc(3); note_key = '0; cyc(16);
      chk("glitch_valid", hit_valid, 0);

      // octave buttons
      press_oct(1, 0, 2, "oct_up1");
      press_oct(1, 0, 2, "oct_up2");
      press_oct(1, 0, 2, "oct_up3");
      press_oct(0, 1, 1, "oct_dn1");
      press_oct(0, 1, 0, "oct_dn2");
      press_oct(0, 1, 0, "oct_dn3");
      press_oct(0, 1, 0, "oct_dn4");
      press_oct(1, 0, 1, "oct_up4");
      press_oct(1, 1, 1, "oct_both");

      // simultaneous rises, default length
      length_key = '0;
      d0 = drops_seen;
      note_key = 7'b0010010;
      wait_valid("simul_latency", 8);
      chk("simul_note", hit_note, 2);
      chk("simul_length", hit_length, 2);
      cyc(2);
      chk("simul_drops", drops_seen - d0, 0);
      note_key = '0; cyc(12); drain();

      // drop while buffer is full, then reload on the handshake edge
      length_key = 4'b0110;
      note_key = 7'b0000001;
      wait_valid("first_latency", 8);
      note_key = '0; cyc(12);
      d0 = drops_seen;
      note_key = 7'b0100000; cyc(16);
      chk("drop_count", drops_seen - d0, 1);
      chk("drop_keep_note", hit_note, 1);
      chk("drop_keep_length", hit_length, 1);
      note_key = '0; cyc(12);
      note_key = 7'b1000000;
      found = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (m_cnt == DEB - 1 && m_samp[6] && !m_stab[6]) begin found = 1; break; end
      end
      chk("third_align", found, 1);
      hit_ready = 1'b1; cyc(1); hit_ready = 1'b0;
      chk("third_valid", hit_valid, 1);
      chk("third_note", hit_note, 7);
      chk("third_drops", drops_seen - d0, 1);
      note_key = '0; cyc(12); drain();

      // key held across enable
      en = 1'b0; note_key = 7'b0000001; cyc(5);
      en = 1'b1; cyc(20);
      chk("en_held_valid", hit_valid, 0);
      chk("en_octave", octave, 1);
      note_key = '0; cyc(12);

      // async reset mid-press
      note_key = 7'b0001000;
      wait_valid("pre_rst_latency", 8);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", hit_valid, 0);
      chk("arst_octave", octave, 1);
      chk("arst_note", hit_note, 0);
      chk("arst_clock", hit_clock, 0);
      @(negedge clk); rst_n = 1'b1;
      wait_valid("post_rst_refire", 10);
      chk("post_rst_note", hit_note, 4);
      note_key = '0; cyc(12); drain();

      // random activity
      for (int c = 0; c < 4000; c++) begin
         int k;
         @(negedge clk);
         if ($urandom_range(0, 9) == 0) begin
            k = int'($urandom_range(0, 6));
            note_key[k] = ~note_key[k];
         end
         if ($urandom_range(0, 29) == 0) length_key = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 39) == 0) oct_up = ~oct_up;
         if ($urandom_range(0, 39) == 0) oct_down = ~oct_down;
         hit_ready = ($urandom_range(0, 3) == 0);
         if (en && $urandom_range(0, 499) == 0) en = 1'b0;
         else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
         if (c == 2000) begin
            #2 rst_n = 1'b0;
            @(negedge clk); rst_n = 1'b1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
